// File: rtl/fir_mac_detect.sv
// rtl/fir_mac_detect.sv - time-multiplexed N-tap unsigned FIR with shared MAC and hysteresis detector
module fir_mac_detect #(
  parameter int NTAPS = 9,
  parameter int XW    = 4,
  parameter int CW    = 4,
  parameter int ACCW  = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [XW-1:0]            x_in,
  input  logic                     x_valid,
  output logic                     x_ready,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [CW-1:0]            coef_data,
  input  logic [ACCW-1:0]          thresh_hi,
  input  logic [ACCW-1:0]          thresh_lo,
  output logic [ACCW-1:0]          y_sum,
  output logic                     y_valid,
  output logic                     y_det,
  output logic                     busy
);
  localparam int IW = $clog2(NTAPS);
  localparam int AW = XW + CW + IW;
  localparam int SW = (AW > ACCW) ? AW : ACCW;
  localparam logic [SW-1:0] SAT_MAX  = SW'({ACCW{1'b1}});
  localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);
  localparam logic [IW:0]   NTAPS_W  = (IW + 1)'(NTAPS);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_nxt;

  logic [XW-1:0]   d [NTAPS];
  logic [CW-1:0]   c [NTAPS];
  logic [AW-1:0]   acc;
  logic [AW-1:0]   prod;
  logic [IW-1:0]   idx;
  logic [SW-1:0]   acc_ext;
  logic [ACCW-1:0] sum_sat;
  logic            accept;
  logic            coef_ok;

  assign x_ready = (state == IDLE) && !rst;
  assign busy    = (state != IDLE);
  assign accept  = x_ready && x_valid;
  assign coef_ok = coef_we && (state == IDLE) && ({1'b0, coef_addr} < NTAPS_W);
  assign prod    = AW'(c[idx]) * AW'(d[idx]);
  assign acc_ext = SW'(acc);
  assign sum_sat = (acc_ext > SAT_MAX) ? ACCW'(SAT_MAX) : ACCW'(acc_ext);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (idx == LAST_IDX) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        d[i] <= '0;
        c[i] <= '0;
      end
      acc     <= '0;
      idx     <= '0;
      y_sum   <= '0;
      y_det   <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= (state == OUT);
      // A coefficient written in the accept cycle is already in place for the first MAC step
      if (coef_ok) c[coef_addr] <= coef_data;
      case (state)
        IDLE: if (accept) begin
          for (int i = NTAPS - 1; i > 0; i--) d[i] <= d[i-1];
          d[0] <= x_in;
          acc  <= '0;
          idx  <= '0;
        end
        MAC: begin
          acc <= acc + prod;
          idx <= idx + IW'(1);
        end
        OUT: begin
          y_sum <= sum_sat;
          if (!y_det && (sum_sat > thresh_hi))     y_det <= 1'b1;
          else if (y_det && (sum_sat < thresh_lo)) y_det <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
